seq_shift_add_mult: RTL and testbench

- Sequential unsigned N×N multiplier; the controller stage directly upstream of the team's 4-bit ripple-carry adder block.
- Drives the adder's a/b/cin inputs each cycle and consumes its sum/cout outputs.
- Uses the classic shift-add algorithm: one partial-product iteration per clock.
- Presents a start/busy/done handshake to the surrounding datapath.

---
 rtl/seq_shift_add_mult_if.sv | 43 ++++
 rtl/seq_shift_add_mult.sv | 114 +++++++++++
 tb/tb_seq_shift_add_mult.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_shift_add_mult_if.sv
// seq_shift_add_mult_if
//   Bundle of the multiplier's handshake, operand/result bus and the link
//   to the external N-bit ripple-carry adder.
//
//   Handshake: start is a request that is accepted only on a rising clock
//   edge where the multiplier is idle (busy=0). Requests made while busy=1
//   are dropped, not queued. busy rises on the accept edge. done is a
//   one-cycle pulse on the edge where product becomes valid, and busy falls
//   on that same edge. product holds its value until the next done.
//
//   Signals:
//     start, a_in, b_in        : request and operands (into the multiplier)
//     busy, done, product      : status and result (out of the multiplier)
//     add_a, add_b, add_cin    : adder operands (out of the multiplier)
//     add_sum, add_cout        : adder result (into the multiplier)
//
//   Modports: slave = multiplier side, master = the surrounding datapath
//   together with the adder.
interface seq_shift_add_mult_if #(
  parameter int N = 4
);
  logic           start;
  logic [N-1:0]   a_in;
  logic [N-1:0]   b_in;
  logic           busy;
  logic           done;
  logic [2*N-1:0] product;
  logic [N-1:0]   add_a;
  logic [N-1:0]   add_b;
  logic           add_cin;
  logic [N-1:0]   add_sum;
  logic           add_cout;

  modport slave (
    input  start, a_in, b_in, add_sum, add_cout,
    output busy, done, product, add_a, add_b, add_cin
  );

  modport master (
    output start, a_in, b_in, add_sum, add_cout,
    input  busy, done, product, add_a, add_b, add_cin
  );
endinterface

// File: rtl/seq_shift_add_mult.sv
// seq_shift_add_mult
//   Sequential unsigned N x N shift-add multiplier. One partial-product
//   iteration per clock, using an external N-bit adder for the A + M step.
//   The product is valid N edges after the accept edge.
//
//   Ports:
//     clk      : system clock, rising edge
//     rst_n    : asynchronous active-low reset
//     bus      : handshake, operands, result and adder link (slave modport)
//     state_o  : current controller state (0 = IDLE, 1 = RUN), debug only
module seq_shift_add_mult #(
  parameter int N = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  seq_shift_add_mult_if.slave  bus,
  output logic                 state_o
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [N-1:0]   m_q, m_d;
  logic [N-1:0]   a_q, a_d;
  logic [N-1:0]   q_q, q_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [2*N-1:0] product_q, product_d;

  logic [N-1:0]   add_a_w;
  logic [N-1:0]   add_b_w;
  logic [2*N-1:0] shift_w;

  // {add_cout, add_sum, Q} shifted right by one: the carry lands in the A
  // MSB and the sum LSB moves into the Q MSB. Q[0] has been consumed.
  assign shift_w = {bus.add_cout, bus.add_sum, q_q[N-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      a_q       <= '0;
      q_q       <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      a_q       <= a_d;
      q_q       <= q_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      product_q <= product_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    a_d       = a_q;
    q_d       = q_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    product_d = product_q;
    add_a_w   = '0;
    add_b_w   = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          m_d     = bus.a_in;
          q_d     = bus.b_in;
          a_d     = '0;
          cnt_d   = CW'(N);
          busy_d  = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a_w = a_q;
        add_b_w = q_q[0] ? m_q : '0;
        a_d     = shift_w[2*N-1:N];
        q_d     = shift_w[N-1:0];
        cnt_d   = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          product_d = shift_w;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.add_a   = add_a_w;
  assign bus.add_b   = add_b_w;
  assign bus.add_cin = 1'b0;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.product = product_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_seq_shift_add_mult.sv
module tb_seq_shift_add_mult;

  localparam int N = 4;

  logic clk;
  logic rst_n;
  logic state_dbg;

  seq_shift_add_mult_if #(.N(N)) ifc ();

  seq_shift_add_mult #(.N(N)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (ifc.slave),
    .state_o (state_dbg)
  );

  // Behavioural 4-bit ripple-carry adder the multiplier drives.
  logic [N:0] adder_res;
  assign adder_res    = {1'b0, ifc.add_a} + {1'b0, ifc.add_b} + {{N{1'b0}}, ifc.add_cin};
  assign ifc.add_sum  = adder_res[N-1:0];
  assign ifc.add_cout = adder_res[N];

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  // ---------------- bookkeeping ----------------
  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // An accepted request becomes a result a*b that is due N edges later.
  logic [2*N-1:0] exp_q[$];
  int             m_cnt    = 0;
  logic           exp_done = 1'b0;
  logic [2*N-1:0] held     = '0;
  logic           chk_addb = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt    = 0;
      exp_done = 1'b0;
      held     = '0;
      exp_q.delete();
    end else begin
      exp_done = 1'b0;
      if (m_cnt == 0) begin
        if (ifc.start) begin
          exp_q.push_back((2*N)'(ifc.a_in * ifc.b_in));
          m_cnt = N;
        end
      end else begin
        m_cnt--;
        if (m_cnt == 0) exp_done = 1'b1;
      end
    end
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [2*N-1:0] e;
    if (rst_n) begin
      chk("busy", 32'(ifc.busy), 32'(m_cnt != 0));
      chk("done", 32'(ifc.done), 32'(exp_done));
      chk("add_cin", 32'(ifc.add_cin), 32'd0);
      if (m_cnt == 0 && !exp_done) begin
        chk("idle_add_a", 32'(ifc.add_a), 32'd0);
        chk("idle_add_b", 32'(ifc.add_b), 32'd0);
      end
      if (chk_addb && m_cnt != 0)
        chk("run_add_b", 32'(ifc.add_b), 32'hF);
      if (ifc.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'(ifc.done), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("product", 32'(ifc.product), 32'(e));
          held = e;
        end
      end else begin
        chk("product_hold", 32'(ifc.product), 32'(held));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b);
    @(negedge clk);
    ifc.start = 1'b1;
    ifc.a_in  = a;
    ifc.b_in  = b;
    @(negedge clk);
    ifc.start = 1'b0;
    repeat (N + 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_n     = 1'b0;
    ifc.start = 1'b0;
    ifc.a_in  = '0;
    ifc.b_in  = '0;
    idle(3);
    chk("reset_busy", 32'(ifc.busy), 32'd0);
    chk("reset_done", 32'(ifc.done), 32'd0);
    chk("reset_product", 32'(ifc.product), 32'd0);
    chk("reset_state", 32'(state_dbg), 32'd0);
    #2 rst_n = 1'b1;

    // Directed cases
    run_op(4'd3, 4'd5);
    idle(2);
    chk_addb = 1'b1;
    run_op(4'd15, 4'd15);
    chk_addb = 1'b0;
    run_op(4'd0, 4'd9);
    run_op(4'd9, 4'd0);

    // Second request during RUN is dropped
    @(negedge clk);
    ifc.start = 1'b1; ifc.a_in = 4'd6; ifc.b_in = 4'd7;
    @(negedge clk);
    ifc.start = 1'b0;
    @(negedge clk);
    ifc.start = 1'b1; ifc.a_in = 4'd1; ifc.b_in = 4'd1;
    @(negedge clk);
    ifc.start = 1'b0;
    idle(6);

    // Asynchronous reset mid-operation
    @(negedge clk);
    ifc.start = 1'b1; ifc.a_in = 4'd13; ifc.b_in = 4'd11;
    @(negedge clk);
    ifc.start = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(ifc.busy), 32'd0);
    chk("midrst_done", 32'(ifc.done), 32'd0);
    chk("midrst_product", 32'(ifc.product), 32'd0);
    chk("midrst_state", 32'(state_dbg), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    idle(2);
    run_op(4'd2, 4'd3);

    // start held high: back-to-back operations
    @(negedge clk);
    ifc.start = 1'b1; ifc.a_in = 4'd4; ifc.b_in = 4'd4;
    @(negedge clk);
    ifc.a_in = 4'd5; ifc.b_in = 4'd5;
    idle(N + 1);
    ifc.start = 1'b0;
    idle(N + 2);

    // Randomized traffic, including stray requests while busy
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      ifc.start = 1'b1;
      ifc.a_in  = N'($urandom_range(0, 15));
      ifc.b_in  = N'($urandom_range(0, 15));
      for (int k = 0; k < N + 1; k++) begin
        @(negedge clk);
        if ($urandom_range(0, 3) == 0) begin
          ifc.start = 1'b1;
          ifc.a_in  = N'($urandom_range(0, 15));
          ifc.b_in  = N'($urandom_range(0, 15));
        end else begin
          ifc.start = 1'b0;
        end
      end
      ifc.start = 1'b0;
      idle($urandom_range(0, 2));
    end
    ifc.start = 1'b0;
    idle(2 * N + 4);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
